// File: rtl/vram_write_arbiter.sv
// ============================================================================
// vram_write_arbiter
// ----------------------------------------------------------------------------
// Purpose
//   Shares the single-port name RAM (64x64 tile map, one word per tile) between
//   display scan fetches and CPU writes. The RAM makes one access per dot_clk.
//   A scan fetch always gets the RAM in its cycle. CPU writes are buffered in a
//   small FIFO and retire in slots the display does not use, in the order they
//   arrived. All RAM-side signals leave through one output register, so every
//   RAM access appears one cycle after it is arbitrated. The display pipeline
//   accounts for that extra cycle.
//
// Configuration
//   VRAM_BLANK_ONLY_EN  When defined, CPU writes retire only while 'blank' is
//                       high, even in cycles with no scan fetch. When it is
//                       undefined, 'blank' is ignored and writes use every
//                       non-fetch slot.
//
// Parameters
//   DEPTH   CPU write FIFO entries (power of two, >= 2)
//   ADDR_W  RAM word address width
//   DATA_W  RAM word width ({tile_name[7:0], tile_attr[7:0]})
//
// Ports
//   dot_clk    in   pixel clock; the only clock
//   reset      in   synchronous, active-high
//   cpu_valid  in   CPU write request
//   cpu_addr   in   CPU write word address
//   cpu_data   in   CPU write data
//   cpu_ready  out  FIFO can accept; a transfer is cpu_valid & cpu_ready
//   scan_fetch in   display needs the RAM this cycle
//   scan_addr  in   display read address
//   blank      in   display in blanking (used only with VRAM_BLANK_ONLY_EN)
//   ram_addr   out  registered RAM address
//   ram_we     out  registered RAM write enable
//   ram_wdata  out  registered RAM write data
//   pending    out  FIFO occupancy, 0..DEPTH
//   overflow   out  sticky: cpu_valid seen while the FIFO was full
// ============================================================================
module vram_write_arbiter #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
) (
    input  logic                     dot_clk,
    input  logic                     reset,

    input  logic                     cpu_valid,
    input  logic [ADDR_W-1:0]        cpu_addr,
    input  logic [DATA_W-1:0]        cpu_data,
    output logic                     cpu_ready,

    input  logic                     scan_fetch,
    input  logic [ADDR_W-1:0]        scan_addr,
    input  logic                     blank,

    output logic [ADDR_W-1:0]        ram_addr,
    output logic                     ram_we,
    output logic [DATA_W-1:0]        ram_wdata,

    output logic [$clog2(DEPTH):0]   pending,
    output logic                     overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_entry_t;

    // ------------------------------------------------------------------------
    // FIFO storage and pointers
    // ------------------------------------------------------------------------
    wr_entry_t        fifo_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    wr_entry_t        head;

    // ------------------------------------------------------------------------
    // Arbitration decisions for the current cycle
    // ------------------------------------------------------------------------
    logic             write_ok;
    logic             push;
    logic             pop;
    logic [CNT_W-1:0] pending_nxt;

`ifdef VRAM_BLANK_ONLY_EN
    assign write_ok = blank;
`else
    // blank has no function in this build; it is kept only so both builds
    // share one port list.
    logic unused_blank;
    assign unused_blank = blank;
    assign write_ok     = 1'b1;
`endif

    // Readiness comes only from registered occupancy, so a pop in the same
    // cycle cannot open a slot for a push while the FIFO is full.
    assign cpu_ready = (pending != CNT_W'(DEPTH));
    assign push      = cpu_valid & cpu_ready;

    // An entry pushed this cycle is not yet counted in 'pending', so the
    // earliest it can retire is the next cycle.
    assign pop       = ~scan_fetch & (pending != '0) & write_ok;

    assign head      = fifo_mem[rd_ptr];

    // NOTE: combinational blocks use blocking '=' and give every output a
    // default at the top, so no path leaves a value unassigned and no latch
    // is inferred. Clocked blocks use non-blocking '<=' so all registers
    // update together from the values they had before the edge.
    always_comb begin
        pending_nxt = pending;
        unique case ({push, pop})
            2'b10:   pending_nxt = pending + CNT_W'(1);
            2'b01:   pending_nxt = pending - CNT_W'(1);
            default: pending_nxt = pending;
        endcase
    end

    // NOTE: the FIFO storage has no reset. Reset clears the pointers and the
    // occupancy, which is enough to make stale entries unreachable, and a
    // reset-free array maps onto plain RAM or register files.
    always_ff @(posedge dot_clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= '{addr: cpu_addr, data: cpu_data};
        end
    end

    // Pointers are exactly log2(DEPTH) bits wide and wrap on their own
    // because DEPTH is a power of two. The 'pending' count tells full from
    // empty when the two pointers are equal.
    always_ff @(posedge dot_clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            pending <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            pending <= pending_nxt;
        end
    end

    // A rejected request is not lost: the requester keeps cpu_valid high
    // until it is accepted. The flag only records that backpressure happened.
    always_ff @(posedge dot_clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (cpu_valid && !cpu_ready) begin
            overflow <= 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // RAM output register
    //   scan fetch : drive the display address, read (ram_wdata keeps its value)
    //   pop        : write the FIFO head
    //   otherwise  : no write, address and data keep their values
    // ------------------------------------------------------------------------
    always_ff @(posedge dot_clk) begin
        if (reset) begin
            ram_addr  <= '0;
            ram_we    <= 1'b0;
            ram_wdata <= '0;
        end else if (scan_fetch) begin
            ram_addr  <= scan_addr;
            ram_we    <= 1'b0;
        end else if (pop) begin
            ram_addr  <= head.addr;
            ram_wdata <= head.data;
            ram_we    <= 1'b1;
        end else begin
            ram_we    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vram_write_arbiter.sv
// ============================================================================
// tb_vram_write_arbiter
//   Directed scenarios followed by a randomized run. The reference model keeps
//   the write buffer as a queue and works out, cycle by cycle, which access
//   the RAM should see. It also tracks the sticky overflow flag. Every cycle
//   the DUT outputs are compared with the model 1 ns after the clock edge.
// ============================================================================
module tb_vram_write_arbiter;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 16;
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    logic              dot_clk = 1'b0;
    logic              reset;
    logic              cpu_valid;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_data;
    logic              cpu_ready;
    logic              scan_fetch;
    logic [ADDR_W-1:0] scan_addr;
    logic              blank;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_wdata;
    logic [CNT_W-1:0]  pending;
    logic              overflow;

    vram_write_arbiter #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .dot_clk    (dot_clk),
        .reset      (reset),
        .cpu_valid  (cpu_valid),
        .cpu_addr   (cpu_addr),
        .cpu_data   (cpu_data),
        .cpu_ready  (cpu_ready),
        .scan_fetch (scan_fetch),
        .scan_addr  (scan_addr),
        .blank      (blank),
        .ram_addr   (ram_addr),
        .ram_we     (ram_we),
        .ram_wdata  (ram_wdata),
        .pending    (pending),
        .overflow   (overflow)
    );

    always #5 dot_clk = ~dot_clk;

    // ------------------------------------------------------------------------
    // Reference model state
    // ------------------------------------------------------------------------
    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    wr_t               m_q[$];
    logic [ADDR_W-1:0] m_addr;
    logic              m_we;
    logic [DATA_W-1:0] m_wdata;
    logic              m_over;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_ready();
        return m_q.size() != DEPTH;
    endfunction

    // One dot_clk cycle with the inputs as currently driven. The model decides
    // from its state before the edge, moves forward at the edge, and the DUT
    // is compared with it 1 ns later.
    task automatic cycle();
        bit  ready;
        bit  wok;
        bit  do_push;
        bit  do_pop;
        wr_t e;
        ready = model_ready();
`ifdef VRAM_BLANK_ONLY_EN
        wok = blank;
`else
        wok = 1'b1;
`endif
        do_push = cpu_valid && ready;
        do_pop  = !scan_fetch && (m_q.size() != 0) && wok;
        @(posedge dot_clk);
        if (reset) begin
            m_q.delete();
            m_over  = 1'b0;
            m_addr  = '0;
            m_we    = 1'b0;
            m_wdata = '0;
        end else begin
            if (cpu_valid && !ready) m_over = 1'b1;
            if (scan_fetch) begin
                m_addr = scan_addr;
                m_we   = 1'b0;
            end else if (do_pop) begin
                e       = m_q.pop_front();
                m_addr  = e.addr;
                m_wdata = e.data;
                m_we    = 1'b1;
            end else begin
                m_we = 1'b0;
            end
            if (do_push) m_q.push_back('{addr: cpu_addr, data: cpu_data});
        end
        #1;
        check("pending",   32'(pending),   32'(m_q.size()));
        check("cpu_ready", 32'(cpu_ready), 32'(model_ready()));
        check("overflow",  32'(overflow),  32'(m_over));
        check("ram_we",    32'(ram_we),    32'(m_we));
        check("ram_addr",  32'(ram_addr),  32'(m_addr));
        check("ram_wdata", 32'(ram_wdata), 32'(m_wdata));
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        cpu_valid = 1'b0;
        cycle();
        reset     = 1'b0;
    endtask

    initial begin
        int idx;
        bit acc;

        reset      = 1'b1;
        cpu_valid  = 1'b0;
        cpu_addr   = '0;
        cpu_data   = '0;
        scan_fetch = 1'b0;
        scan_addr  = '0;
        blank      = 1'b1;
        m_addr     = '0;
        m_we       = 1'b0;
        m_wdata    = '0;
        m_over     = 1'b0;

        // Power-up reset
        cycle();
        cycle();
        reset = 1'b0;
        check("reset_pending", 32'(pending), 32'd0);
        check("reset_ready",   32'(cpu_ready), 32'd1);

        // Reset mid-operation: queue 3 writes behind a scan fetch, then reset
        scan_fetch = 1'b1;
        scan_addr  = 12'h0AA;
        for (int i = 0; i < 3; i++) begin
            cpu_valid = 1'b1;
            cpu_addr  = ADDR_W'(12'h200 + i);
            cpu_data  = DATA_W'(16'h1000 + i);
            cycle();
        end
        cpu_valid = 1'b0;
        check("midq_pending", 32'(pending), 32'd3);
        scan_fetch = 1'b0;
        reset      = 1'b1;
        cycle();
        reset      = 1'b0;
        check("mid_reset_pending",  32'(pending),  32'd0);
        check("mid_reset_overflow", 32'(overflow), 32'd0);
        check("mid_reset_ready",    32'(cpu_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("mid_reset_no_write", 32'(ram_we), 32'd0);
        end

        // Idle RAM: one write appears after the second edge
        cpu_valid = 1'b1;
        cpu_addr  = 12'h041;
        cpu_data  = 16'hA55A;
        cycle();
        cpu_valid = 1'b0;
        check("idle_not_yet", 32'(ram_we), 32'd0);
        cycle();
        check("idle_we",    32'(ram_we),    32'd1);
        check("idle_addr",  32'(ram_addr),  32'h041);
        check("idle_wdata", 32'(ram_wdata), 32'hA55A);
        check("idle_pend",  32'(pending),   32'd0);
        cycle();

        // Fetch priority: 8 scan cycles with 2 writes queued
        scan_fetch = 1'b1;
        scan_addr  = 12'h100;
        for (int i = 0; i < 8; i++) begin
            cpu_valid = (i < 2);
            cpu_addr  = ADDR_W'(12'h300 + i);
            cpu_data  = DATA_W'(16'hBEE0 + i);
            cycle();
            check("fetch_we",   32'(ram_we),   32'd0);
            check("fetch_addr", 32'(ram_addr), 32'h100);
        end
        cpu_valid  = 1'b0;
        scan_fetch = 1'b0;
        cycle();
        check("fetch_ret1", 32'(ram_addr), 32'h300);
        cycle();
        check("fetch_ret2", 32'(ram_addr), 32'h301);
        cycle();

        // Full FIFO: 5 writes held until accepted behind a scan fetch
        do_reset();
        scan_fetch = 1'b1;
        scan_addr  = 12'h0F0;
        idx        = 0;
        for (int c = 0; c < 14; c++) begin
            if (c == 7) scan_fetch = 1'b0;
            cpu_valid = (idx < 5);
            cpu_addr  = ADDR_W'(12'h400 + idx);
            cpu_data  = DATA_W'(16'hC000 + idx);
            acc = cpu_valid && model_ready();
            cycle();
            if (acc) idx++;
            if (c == 3) check("full_ready", 32'(cpu_ready), 32'd0);
            if (c == 4) check("full_overflow", 32'(overflow), 32'd1);
        end
        cpu_valid = 1'b0;
        check("full_all_in", 32'(idx), 32'd5);

        // Simultaneous push and pop at pending=2
        do_reset();
        scan_fetch = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cpu_valid = 1'b1;
            cpu_addr  = ADDR_W'(12'h500 + i);
            cpu_data  = DATA_W'(16'hD000 + i);
            cycle();
        end
        scan_fetch = 1'b0;
        for (int i = 2; i < 12; i++) begin
            cpu_valid = 1'b1;
            cpu_addr  = ADDR_W'(12'h500 + i);
            cpu_data  = DATA_W'(16'hD000 + i);
            cycle();
            check("pp_pending", 32'(pending), 32'd2);
        end
        cpu_valid = 1'b0;
        for (int i = 0; i < 3; i++) cycle();

        // Blanking: writes queued while blank is low, then blank rises
        blank = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cpu_valid = 1'b1;
            cpu_addr  = ADDR_W'(12'h600 + i);
            cpu_data  = DATA_W'(16'hE000 + i);
            cycle();
        end
        cpu_valid = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        blank = 1'b1;
        for (int i = 0; i < 3; i++) cycle();

        // Randomized traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            reset      = ($urandom_range(0, 79) == 0);
            cpu_valid  = ($urandom_range(0, 2) != 0);
            cpu_addr   = ADDR_W'($urandom);
            cpu_data   = DATA_W'($urandom);
            scan_fetch = ($urandom_range(0, 9) < 6);
            scan_addr  = ADDR_W'($urandom);
            blank      = ($urandom_range(0, 3) != 0);
            cycle();
        end
        reset     = 1'b0;
        cpu_valid = 1'b0;
        scan_fetch = 1'b0;
        blank     = 1'b1;
        for (int i = 0; i < DEPTH + 2; i++) cycle();
        check("drain_pending", 32'(pending), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
